// File: rtl/rf_watch_pkg.sv
// Shared types and helpers for the register-file watch/check engine.
package rf_watch_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CHECK   = 3'd2,
    PASS    = 3'd3,
    FAIL    = 3'd4,
    TIMEOUT = 3'd5
  } ch_state_t;

  // Index width for n items, never below one bit so single-channel builds still have a port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rf_watch_channel.sv
// One watch channel: latched trigger/check config, timeout counter and result FSM.
module rf_watch_channel
  import rf_watch_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int TIMEOUT_W       = 16,
  parameter int TIMEOUT_DEFAULT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 arm,
  input  logic [REG_IDX_W-1:0] cfg_trig_reg,
  input  logic [XLEN-1:0]      cfg_trig_val,
  input  logic [REG_IDX_W-1:0] cfg_chk_reg,
  input  logic [XLEN-1:0]      cfg_chk_val,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic [XLEN-1:0]      trig_data,
  input  logic [XLEN-1:0]      chk_data,
  output logic [REG_IDX_W-1:0] trig_reg,
  output logic [REG_IDX_W-1:0] chk_reg,
  output logic                 active,
  output logic                 enter_fail,
  output logic                 enter_timeout,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] CNT_DEF = TIMEOUT_W'(TIMEOUT_DEFAULT);

  ch_state_t              state_r, state_next_s;
  logic [TIMEOUT_W-1:0]   cnt_r, cnt_next_s, cnt_load_s;
  logic [REG_IDX_W-1:0]   trig_reg_r, chk_reg_r;
  logic [XLEN-1:0]        trig_val_r, chk_val_r;
  logic                   busy_r, pass_r, fail_r, timeout_r;

  assign cnt_load_s = (cfg_timeout == {TIMEOUT_W{1'b0}}) ? CNT_DEF : cfg_timeout;

  // Next state: clear beats arm, arm beats normal advance; a trigger match beats expiry.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (clear) begin
      state_next_s = IDLE;
    end else if (arm) begin
      state_next_s = ARMED;
      cnt_next_s   = cnt_load_s;
    end else begin
      case (state_r)
        ARMED: begin
          if (trig_data == trig_val_r) begin
            state_next_s = CHECK;
          end else if (cnt_r == CNT_ONE) begin
            state_next_s = TIMEOUT;
          end else begin
            cnt_next_s = cnt_r - CNT_ONE;
          end
        end
        CHECK: begin
          if (chk_data == chk_val_r) begin
            state_next_s = PASS;
          end else begin
            state_next_s = FAIL;
          end
        end
        default: state_next_s = state_r;
      endcase
    end
  end

  assign active        = (state_r == ARMED) || (state_r == CHECK);
  assign enter_fail    = (state_r == CHECK) && (state_next_s == FAIL);
  assign enter_timeout = (state_r == ARMED) && (state_next_s == TIMEOUT);
  assign trig_reg      = trig_reg_r;
  assign chk_reg       = chk_reg_r;

  // State and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {TIMEOUT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Latched configuration, captured only on an accepted arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_reg_r <= {REG_IDX_W{1'b0}};
      trig_val_r <= {XLEN{1'b0}};
      chk_reg_r  <= {REG_IDX_W{1'b0}};
      chk_val_r  <= {XLEN{1'b0}};
    end else if (arm && !clear) begin
      trig_reg_r <= cfg_trig_reg;
      trig_val_r <= cfg_trig_val;
      chk_reg_r  <= cfg_chk_reg;
      chk_val_r  <= cfg_chk_val;
    end
  end

  // Registered status decode, one cycle behind the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      busy_r    <= active;
      pass_r    <= (state_r == PASS);
      fail_r    <= (state_r == FAIL);
      timeout_r <= (state_r == TIMEOUT);
    end
  end

  assign busy    = busy_r;
  assign pass    = pass_r;
  assign fail    = fail_r;
  assign timeout = timeout_r;

endmodule

// File: rtl/rf_watch_monitor.sv
// Register-file watch engine: shadows CPU writebacks and runs N_CH trigger/check channels
// with per-channel timeouts, reporting status and the first failing channel.
module rf_watch_monitor
  import rf_watch_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int XLEN            = 32,
  parameter int TIMEOUT_W       = 16,
  parameter int TIMEOUT_DEFAULT = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_valid,
  input  logic [REG_IDX_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          cfg_valid,
  input  logic [clog2_min1(N_CH)-1:0]   cfg_ch,
  input  logic [REG_IDX_W-1:0]          cfg_trig_reg,
  input  logic [XLEN-1:0]               cfg_trig_val,
  input  logic [REG_IDX_W-1:0]          cfg_chk_reg,
  input  logic [XLEN-1:0]               cfg_chk_val,
  input  logic [TIMEOUT_W-1:0]          cfg_timeout,
  input  logic                          clear,
  output logic [N_CH-1:0]               busy,
  output logic [N_CH-1:0]               pass,
  output logic [N_CH-1:0]               fail,
  output logic [N_CH-1:0]               timeout,
  output logic                          all_done,
  output logic                          ff_valid,
  output logic [clog2_min1(N_CH)-1:0]   ff_ch,
  output logic [XLEN-1:0]               ff_got
);

  localparam int CH_W  = clog2_min1(N_CH);
  localparam int N_REG = 2 ** REG_IDX_W;

  logic [XLEN-1:0]      shadow_r [N_REG];
  logic [REG_IDX_W-1:0] trig_reg_s [N_CH];
  logic [REG_IDX_W-1:0] chk_reg_s [N_CH];
  logic [XLEN-1:0]      trig_data_s [N_CH];
  logic [XLEN-1:0]      chk_data_s [N_CH];
  logic [N_CH-1:0]      arm_s, active_s, enter_fail_s, enter_timeout_s;
  logic                 hit_s;
  logic [CH_W-1:0]      hit_ch_s;
  logic [XLEN-1:0]      hit_got_s;
  logic                 ff_valid_r, started_r, all_done_r;
  logic [CH_W-1:0]      ff_ch_r;
  logic [XLEN-1:0]      ff_got_r;

  // Shadow register file; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REG; i++) shadow_r[i] <= {XLEN{1'b0}};
    end else if (wb_valid && (wb_rd != {REG_IDX_W{1'b0}})) begin
      shadow_r[wb_rd] <= wb_data;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign arm_s[g]       = cfg_valid && (cfg_ch == CH_W'(g));
    assign trig_data_s[g] = shadow_r[trig_reg_s[g]];
    assign chk_data_s[g]  = shadow_r[chk_reg_s[g]];

    rf_watch_channel #(
      .XLEN            (XLEN),
      .TIMEOUT_W       (TIMEOUT_W),
      .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .arm           (arm_s[g]),
      .cfg_trig_reg  (cfg_trig_reg),
      .cfg_trig_val  (cfg_trig_val),
      .cfg_chk_reg   (cfg_chk_reg),
      .cfg_chk_val   (cfg_chk_val),
      .cfg_timeout   (cfg_timeout),
      .trig_data     (trig_data_s[g]),
      .chk_data      (chk_data_s[g]),
      .trig_reg      (trig_reg_s[g]),
      .chk_reg       (chk_reg_s[g]),
      .active        (active_s[g]),
      .enter_fail    (enter_fail_s[g]),
      .enter_timeout (enter_timeout_s[g]),
      .busy          (busy[g]),
      .pass          (pass[g]),
      .fail          (fail[g]),
      .timeout       (timeout[g])
    );
  end

  // Lowest-index channel entering FAIL/TIMEOUT this cycle; scanning downward lets it win.
  always_comb begin
    hit_s     = 1'b0;
    hit_ch_s  = {CH_W{1'b0}};
    hit_got_s = {XLEN{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (enter_fail_s[i] || enter_timeout_s[i]) begin
        hit_s     = 1'b1;
        hit_ch_s  = CH_W'(i);
        hit_got_s = enter_fail_s[i] ? chk_data_s[i] : {XLEN{1'b0}};
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Sticky first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_valid_r <= 1'b0;
      ff_ch_r    <= {CH_W{1'b0}};
      ff_got_r   <= {XLEN{1'b0}};
    end else if (clear) begin
      ff_valid_r <= 1'b0;
      ff_ch_r    <= {CH_W{1'b0}};
      ff_got_r   <= {XLEN{1'b0}};
    end else if (!ff_valid_r && hit_s) begin
      ff_valid_r <= 1'b1;
      ff_ch_r    <= hit_ch_s;
      ff_got_r   <= hit_got_s;
    end
  end

  // all_done needs at least one arm since reset/clear and nothing still waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_r  <= 1'b0;
      all_done_r <= 1'b0;
    end else begin
      all_done_r <= started_r && !(|active_s);
      started_r  <= clear ? 1'b0 : (started_r || (|arm_s));
    end
  end

  assign all_done = all_done_r;
  assign ff_valid = ff_valid_r;
  assign ff_ch    = ff_ch_r;
  assign ff_got   = ff_got_r;

endmodule

// File: doc/rf_watch_monitor.md
Name: rf_watch_monitor

Overview:
- Parametrised register-file watch/check engine: snoops the CPU writeback port, keeps a shadow copy of the 32 architectural registers, and runs N_CH independent "wait for trigger register == value, then check another register" channels, each with its own timeout.
- Sits beside Riscv151 in simulation and FPGA bring-up builds.
- Replaces per-test hand-written wait/check/timeout logic with a reusable block that reports pass/fail/timeout per channel and captures the first failure.

Parameters:
- N_CH, 4, number of independent watch channels (1..16)
- XLEN, 32, register data width
- TIMEOUT_W, 16, width of per-channel timeout counter
- TIMEOUT_DEFAULT, 1000, timeout loaded when cfg_timeout==0

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (rst==0 resets)
- wb_valid  in  1  CPU register writeback strobe
- wb_rd  in  5  writeback destination register
- wb_data  in  XLEN  writeback data
- cfg_valid  in  1  arm channel cfg_ch this cycle
- cfg_ch  in  $clog2(N_CH) (min 1)  channel to arm
- cfg_trig_reg  in  5  trigger register index
- cfg_trig_val  in  XLEN  trigger value
- cfg_chk_reg  in  5  check register index
- cfg_chk_val  in  XLEN  expected value
- cfg_timeout  in  TIMEOUT_W  cycle budget; 0 selects TIMEOUT_DEFAULT
- clear  in  1  synchronous: all channels to IDLE, first-fail capture cleared
- busy  out  N_CH  channel in ARMED or CHECK
- pass  out  N_CH  channel in PASS
- fail  out  N_CH  channel in FAIL
- timeout  out  N_CH  channel in TIMEOUT
- all_done  out  1  no channel busy and at least one channel has left IDLE since reset/clear
- ff_valid  out  1  first-fail capture valid
- ff_ch  out  $clog2(N_CH)  channel of first FAIL/TIMEOUT
- ff_got  out  XLEN  shadow[chk_reg] at the failing check (0 for timeout)

Behaviour:
- Reset (rst low, async): shadow regs all 0; channels IDLE; all outputs 0; ff_* 0.
- Shadow: on wb_valid with wb_rd!=0, shadow[wb_rd] <= wb_data at posedge. Writes to x0 are ignored; shadow[0] is always 0.
- Channel FSM: IDLE -> ARMED -> CHECK -> {PASS, FAIL}; ARMED -> TIMEOUT.
  - IDLE: when cfg_valid and cfg_ch==i, latch cfg fields, load counter (cfg_timeout or TIMEOUT_DEFAULT), go ARMED.
  - ARMED: compare the registered shadow[trig_reg] against trig_val.
    - Match: go to CHECK.
    - Else if counter==1: go to TIMEOUT.
    - Else: decrement counter.
    - Trigger match and expiry in the same cycle: match wins.
    - A writeback is visible to the trigger compare one cycle after wb_valid, because the compare uses the registered shadow.
  - CHECK (1 cycle): shadow[chk_reg]==chk_val -> PASS, else FAIL. The value is sampled in CHECK, so a writeback landing in the CHECK cycle is not seen.
  - PASS/FAIL/TIMEOUT: hold until re-armed or cleared.
- Re-arm: cfg_valid to a channel in any state restarts it in ARMED with the new config and a fresh counter.
- Priority: clear > cfg_valid > FSM advance. clear and cfg_valid in the same cycle: clear wins, arm is dropped.
- Status outputs are registered decodes of state; they update the cycle after the state transition.
- First-fail capture:
  - Loaded when ff_valid==0 and some channel enters FAIL or TIMEOUT; the lowest index wins on simultaneous entries.
  - Sticky until clear or reset; re-arming channels does not clear it.
- Trigger with trig_reg==0 and trig_val==0 matches on the first ARMED cycle (immediate check).
- Reset mid-operation: everything returns to reset values; no completion is reported.

Decomposition:
- Package rf_watch_pkg holds:
  - ch_state_t enum (IDLE, ARMED, CHECK, PASS, FAIL, TIMEOUT)
  - REG_IDX_W=5
  - helper function clog2_min1
- One sub-module, rf_watch_channel: a single channel FSM plus counter and latched config. It takes the two shadow read values (trigger/check) as inputs.
- The top level holds the shadow file, the read muxes, the channel generate loop, and the first-fail priority encoder.

Test Plan:
- Basic pass: arm ch0 trig x20==1, chk x1==300, timeout 1000; write x1=300, then x20=1 -> pass[0]=1 within 3 cycles of the x20 writeback; all_done=1; ff_valid=0.
- Check fail: same as basic pass but x1=299 -> fail[0]=1, ff_valid=1, ff_ch=0, ff_got=299.
- Timeout: arm ch1 with cfg_timeout=10, never write the trigger -> timeout[1]=1 exactly 10 cycles after arming (+1 output register); ff_ch=1, ff_got=0.
- Simultaneous: arm ch2 and ch3 (consecutive cycles), both fail checks whose triggers are the same x5 write -> ff_ch=2; fail[2] and fail[3] both set.
- x0 and immediate trigger: write x0=7 -> shadow[0] stays 0; arm trig x0==0, chk x0==0 -> pass within 3 cycles.
- Clear/reset/re-arm:
  - clear while ch0 is ARMED -> busy=0, all_done=0.
  - Re-arm a FAILed channel -> busy set, fail cleared, ff_* retained.
  - Async rst low mid-ARMED -> all outputs 0 immediately.
